adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Scan sequencer for the shared 8-bit ADC sampler in the roof sensor front end. It steps an external analog multiplexer across the enabled sensor channels and waits a settling time after each switch. It then averages a fixed number of sampler outputs per channel and stores one result per channel in a readable register file. Scans start periodically, or on a single-shot request from the system controller.

## Interface
- N_CH, 4, number of analog mux channels (2..16)
- SEL_W, 2, mux select width, ≥ clog2(N_CH)
- SETTLE_CYC, 64, i_clk cycles to wait after a mux switch (≥1)
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
- SCAN_PERIOD, 50000, i_clk cycles between periodic scan triggers (1 ms at 50 MHz)
- i_clk, in, 1, system clock, 50 MHz
- i_rst_n, in, 1, asynchronous active-low reset
- i_en, in, 1, enables the periodic scan timer
- i_start, in, 1, single-cycle scan request, independent of i_en
- i_ch_mask, in, N_CH, channel enable mask, latched at scan start
- i_smp_valid, in, 1, one-cycle strobe from the sampler when a new sample is available
- i_smp_data, in, 8, sampler output, valid with i_smp_valid
- i_rd_ch, in, SEL_W, register-file read address
- o_rd_data, out, 8, combinational read of the stored result for i_rd_ch
- o_mux_sel, out, SEL_W, analog mux select, registered
- o_busy, out, 1, high from scan start until scan completion
- o_res_valid, out, 1, one-cycle pulse when a channel result is stored
- o_res_ch, out, SEL_W, channel of the current result
- o_res_data, out, 8, averaged result
- o_scan_done, out, 1, one-cycle pulse at the end of a scan
- o_overrun, out, 1, one-cycle pulse when a trigger arrives while busy

## Operation
- Trigger = i_start OR timer tick.
  - Timer counts 0..SCAN_PERIOD-1 while i_en=1 and ticks on wrap.
  - Timer holds at 0 while i_en=0.
- States: IDLE, SETTLE, ACCUM, STORE.
- IDLE, on trigger:
  - Latch i_ch_mask.
  - Mask all zero: pulse o_scan_done, stay IDLE, leave o_mux_sel and o_busy unchanged.
  - Otherwise: load o_mux_sel with the lowest enabled channel, load the settle counter with SETTLE_CYC-1, set o_busy, go to SETTLE.
- SETTLE: decrement the counter each cycle. At 0, clear the accumulator and sample count and go to ACCUM. Any i_smp_valid seen in SETTLE is ignored.
- ACCUM: on each i_smp_valid, acc += i_smp_data.
  - Accumulator width is 8+AVG_LOG2, so it cannot overflow.
  - When the 2^AVG_LOG2-th sample is accepted, go to STORE.
- STORE (exactly one cycle):
  - o_res_valid=1, o_res_ch=o_mux_sel, o_res_data=acc>>AVG_LOG2 (truncating).
  - Register-file entry [o_res_ch] is written at the end of the cycle.
  - If a higher enabled channel remains in the latched mask: o_mux_sel ← that channel, reload the settle counter, go to SETTLE.
  - Otherwise: o_scan_done=1 in this same cycle, clear o_busy, go to IDLE.
- Triggers while not in IDLE are dropped and pulse o_overrun. A trigger is never queued.
- i_en falling mid-scan: the current scan completes normally.
- i_ch_mask changes mid-scan have no effect on the scan in progress.

## Timing
- Reset (async): state IDLE, timer 0. All outputs 0, including o_mux_sel=0. Register file cleared, so o_rd_data=0.
- Trigger sampled at edge T: o_mux_sel and o_busy are valid after edge T+1.
- Each channel spends SETTLE_CYC cycles in SETTLE.
- The first i_smp_valid that can count is in the cycle after SETTLE ends.
- o_res_valid is high in the cycle after the edge that accepted the final sample.
- o_rd_data reflects a new result from the cycle after STORE.
- Empty-mask trigger at edge T: o_scan_done is high in cycle T+1.
- i_start coincident with a timer tick counts as a single trigger, with no overrun.
- Reset asserted mid-scan aborts immediately. No partial result is written.

## Test plan
Bench parameters: N_CH=4, SETTLE_CYC=4, AVG_LOG2=2, SCAN_PERIOD=200.

1. Reset and idle:
   - Assert i_rst_n=0 at an arbitrary time → all outputs 0, o_rd_data=0 for every i_rd_ch.
   - Keep i_en=0 with no i_start for 1000 cycles → o_busy stays 0.
2. Two-channel scan, mask=4'b0101, i_start:
   - Ch0 fed 10,11,12,13 → o_res_ch=0, o_res_data=11.
   - o_mux_sel=2, then ch2 fed 255×4 → o_res_data=255, with o_scan_done coincident.
   - o_rd_data at addresses 0 and 2 reads 11 and 255.
3. Settling discard: strobe 200 during SETTLE, then 8×4 in ACCUM → result 8.
4. Empty mask=0 with i_start → o_scan_done one cycle later, o_busy never 1, o_mux_sel unchanged.
5. Periodic and overrun, i_en=1:
   - Triggers occur every 200 cycles.
   - i_start pulsed mid-scan → one o_overrun pulse and no extra scan.
   - i_en dropped mid-scan → that scan completes and no further periodic scans start.
6. Reset mid-ACCUM (after 2 of 4 samples) → outputs 0 asynchronously and the entry stays 0. The next i_start restarts at the lowest enabled channel.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for the shared 8-bit ADC: steps the analog mux over the enabled channels,
// waits for settling, averages 2^AVG_LOG2 samples per channel and keeps one result per channel.
module adc_scan_ctrl #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SCAN_PERIOD = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [N_CH-1:0]  i_ch_mask,
    input  logic             i_smp_valid,
    input  logic [7:0]       i_smp_data,
    input  logic [SEL_W-1:0] i_rd_ch,
    output logic [7:0]       o_rd_data,
    output logic [SEL_W-1:0] o_mux_sel,
    output logic             o_busy,
    output logic             o_res_valid,
    output logic [SEL_W-1:0] o_res_ch,
    output logic [7:0]       o_res_data,
    output logic             o_scan_done,
    output logic             o_overrun
);

    localparam int unsigned ACC_W = 8 + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TMR_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_SMP    = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(SCAN_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StAccum,
        StStore
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               empty_done_q, empty_done_d;
    logic               overrun_q, overrun_d;
    logic               rf_we;
    logic               scan_last;
    logic [7:0]         rf_q [N_CH];

    logic               tick;
    logic               trigger;
    logic               first_found, next_found;
    logic [SEL_W-1:0]   first_ch, next_ch;
    logic [7:0]         res_avg;

    // Free-running period timer; held at zero while the periodic scan is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmr_q <= '0;
        end else if (!i_en || tmr_q == TMR_LAST) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    assign tick    = i_en && (tmr_q == TMR_LAST);
    assign trigger = i_start || tick;
    assign res_avg = acc_q[ACC_W-1:AVG_LOG2];

    // Lowest channel of the live mask starts a scan; the next higher one in the latched mask
    // continues it.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (i_ch_mask[i] && !first_found) begin
                first_found = 1'b1;
                first_ch    = SEL_W'(i);
            end
            if (mask_q[i] && !next_found && (i > int'(mux_sel_q))) begin
                next_found = 1'b1;
                next_ch    = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        mask_d       = mask_q;
        settle_d     = settle_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        empty_done_d = 1'b0;
        overrun_d    = 1'b0;
        rf_we        = 1'b0;
        scan_last    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    mask_d = i_ch_mask;
                    if (!first_found) begin
                        empty_done_d = 1'b1;
                    end else begin
                        mux_sel_d = first_ch;
                        settle_d  = SETTLE_LOAD;
                        busy_d    = 1'b1;
                        state_d   = StSettle;
                    end
                end
            end
            StSettle: begin
                overrun_d = trigger;
                if (settle_q == '0) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAccum;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            StAccum: begin
                overrun_d = trigger;
                if (i_smp_valid) begin
                    acc_d = acc_q + ACC_W'(i_smp_data);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SMP) begin
                        state_d = StStore;
                    end
                end
            end
            StStore: begin
                overrun_d = trigger;
                rf_we     = 1'b1;
                if (next_found) begin
                    mux_sel_d = next_ch;
                    settle_d  = SETTLE_LOAD;
                    state_d   = StSettle;
                end else begin
                    scan_last = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            mux_sel_q    <= '0;
            mask_q       <= '0;
            settle_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            empty_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            mask_q       <= mask_d;
            settle_q     <= settle_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            empty_done_q <= empty_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[mux_sel_q] <= res_avg;
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (32'(i_rd_ch) < N_CH) begin
            o_rd_data = rf_q[i_rd_ch];
        end
    end

    assign o_mux_sel   = mux_sel_q;
    assign o_busy      = busy_q;
    assign o_res_valid = (state_q == StStore);
    assign o_res_ch    = mux_sel_q;
    assign o_res_data  = res_avg;
    assign o_scan_done = empty_done_q || scan_last;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: randomized sample streams and masks checked against
// a channel-list / average / register-file model kept in the bench.
module tb_adc_scan_ctrl;

    localparam int N_CH     = 4;
    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 2;
    localparam int PERIOD   = 200;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       en        = 1'b0;
    logic       start     = 1'b0;
    logic [3:0] ch_mask   = '0;
    logic       smp_valid = 1'b0;
    logic [7:0] smp_data  = '0;
    logic [1:0] rd_ch     = '0;

    logic [7:0] o_rd_data;
    logic [1:0] o_mux_sel;
    logic       o_busy;
    logic       o_res_valid;
    logic [1:0] o_res_ch;
    logic [7:0] o_res_data;
    logic       o_scan_done;
    logic       o_overrun;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ovr_cnt  = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    logic [7:0] exp_rf [N_CH];
    logic [1:0] last_sel = '0;

    adc_scan_ctrl #(
        .N_CH       (N_CH),
        .SEL_W      (2),
        .SETTLE_CYC (SETTLE),
        .AVG_LOG2   (AVG_LOG2),
        .SCAN_PERIOD(PERIOD)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_start    (start),
        .i_ch_mask  (ch_mask),
        .i_smp_valid(smp_valid),
        .i_smp_data (smp_data),
        .i_rd_ch    (rd_ch),
        .o_rd_data  (o_rd_data),
        .o_mux_sel  (o_mux_sel),
        .o_busy     (o_busy),
        .o_res_valid(o_res_valid),
        .o_res_ch   (o_res_ch),
        .o_res_data (o_res_data),
        .o_scan_done(o_scan_done),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_overrun === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
        if (o_scan_done === 1'b1) done_cnt <= done_cnt + 1;
        if (o_busy === 1'b1)      busy_cnt <= busy_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_scan(input logic [3:0] mask);
        ch_mask = mask;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if ({o_mux_sel, o_busy, o_res_valid, o_res_ch, o_res_data, o_scan_done, o_overrun} !== '0)
        begin
            n_err++;
            $display("FAIL %s outputs: sel=%0d busy=%b rv=%b rch=%0d rdata=%0d done=%b ovr=%b want all 0",
                     tag, o_mux_sel, o_busy, o_res_valid, o_res_ch, o_res_data, o_scan_done,
                     o_overrun);
        end
    endtask

    // Entered 1 ns after the edge that switched the mux to ch; leaves in the STORE cycle.
    task automatic feed_channel(input logic [1:0] ch, input bit last, input bit rand_vals,
                                input logic [31:0] vals, input bit garbage, input bit poke);
        int sum;
        int n;
        logic [7:0] d;
        for (int k = 0; k < SETTLE; k++) begin
            smp_valid = garbage ? 1'b1 : 1'($urandom_range(0, 1));
            smp_data  = garbage ? 8'd200 : 8'($urandom);
            start     = poke && (k == 1);
            step();
            if (k == 0) begin
                n_vec++;
                if (o_busy !== 1'b1 || o_mux_sel !== ch) begin
                    n_err++;
                    $display("FAIL settle_state: busy=%b sel=%0d want busy=1 sel=%0d",
                             o_busy, o_mux_sel, ch);
                end
            end
        end
        start = 1'b0;
        sum = 0;
        n   = 0;
        while (n < 4) begin
            if ($urandom_range(0, 3) != 0) begin
                d = rand_vals ? 8'($urandom) : vals[8*n +: 8];
                smp_valid = 1'b1;
                smp_data  = d;
                sum += int'(d);
                n++;
            end else begin
                smp_valid = 1'b0;
                smp_data  = 8'($urandom);
            end
            step();
            if (n < 4) begin
                n_vec++;
                if (o_res_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL early_res_valid ch%0d after %0d samples: got %b want 0",
                             ch, n, o_res_valid);
                end
            end
        end
        smp_valid = 1'b0;
        n_vec++;
        if (o_res_valid !== 1'b1 || o_res_ch !== ch) begin
            n_err++;
            $display("FAIL res_strobe: valid=%b ch=%0d want valid=1 ch=%0d",
                     o_res_valid, o_res_ch, ch);
        end
        n_vec++;
        if (o_res_data !== 8'(sum >> 2)) begin
            n_err++;
            $display("FAIL res_data ch%0d: got %0d want %0d", ch, o_res_data, sum >> 2);
        end
        n_vec++;
        if (o_scan_done !== last) begin
            n_err++;
            $display("FAIL scan_done_at_store ch%0d: got %b want %b", ch, o_scan_done, last);
        end
        exp_rf[ch] = 8'(sum >> 2);
    endtask

    // Entered 1 ns after the trigger edge; mask is the mask latched at that edge.
    task automatic do_scan(input logic [3:0] mask, input bit rand_vals, input logic [31:0] vals0,
                           input logic [31:0] vals1, input bit garbage, input bit poke,
                           input bit drop_en);
        int d0;
        bit first;
        bit is_last;
        d0      = done_cnt;
        first   = 1'b1;
        ch_mask = 4'($urandom);
        if (drop_en) en = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (mask[c]) begin
                is_last = ((32'(mask) >> (c + 1)) == 0);
                feed_channel(2'(c), is_last, rand_vals, first ? vals0 : vals1, garbage,
                             poke && first);
                last_sel = 2'(c);
                first    = 1'b0;
                step();
            end
        end
        n_vec++;
        if (o_busy !== 1'b0 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL scan_end: busy=%b done_pulses=%0d want busy=0 done_pulses=1",
                     o_busy, done_cnt - d0);
        end
        for (int c = 0; c < N_CH; c++) begin
            rd_ch = 2'(c);
            #1;
            n_vec++;
            if (o_rd_data !== exp_rf[c]) begin
                n_err++;
                $display("FAIL rd_data[%0d]: got %0d want %0d", c, o_rd_data, exp_rf[c]);
            end
        end
    endtask

    task automatic test_reset();
        #23;
        check_all_zero("por");
        for (int c = 0; c < N_CH; c++) begin
            rd_ch = 2'(c);
            #1;
            n_vec++;
            if (o_rd_data !== 8'd0) begin
                n_err++;
                $display("FAIL por_rd_data[%0d]: got %0d want 0", c, o_rd_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_scan(4'b0001);
        repeat (2) step();
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_before_reset: got %b want 1", o_busy);
        end
        #($urandom_range(1, 7));
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        int b0;
        int d0;
        b0 = busy_cnt;
        d0 = done_cnt;
        repeat (1000) step();
        n_vec++;
        if (busy_cnt != b0 || done_cnt != d0) begin
            n_err++;
            $display("FAIL idle_activity: busy_cycles=%0d scans=%0d want 0 and 0",
                     busy_cnt - b0, done_cnt - d0);
        end
    endtask

    task automatic test_two_channel();
        start_scan(4'b0101);
        do_scan(4'b0101, 1'b0, {8'd13, 8'd12, 8'd11, 8'd10}, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (exp_rf[0] !== 8'd11 || exp_rf[2] !== 8'd255) begin
            n_err++;
            $display("FAIL two_channel_model: got %0d/%0d want 11/255", exp_rf[0], exp_rf[2]);
        end
    endtask

    task automatic test_settle_discard();
        start_scan(4'b0010);
        do_scan(4'b0010, 1'b0, 32'h0808_0808, 32'h0808_0808, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_empty_mask();
        int b0;
        int d0;
        b0 = busy_cnt;
        d0 = done_cnt;
        start_scan(4'b0000);
        n_vec++;
        if (o_scan_done !== 1'b1 || o_busy !== 1'b0 || o_mux_sel !== last_sel) begin
            n_err++;
            $display("FAIL empty_scan: done=%b busy=%b sel=%0d want done=1 busy=0 sel=%0d",
                     o_scan_done, o_busy, o_mux_sel, last_sel);
        end
        step();
        n_vec++;
        if (o_scan_done !== 1'b0) begin
            n_err++;
            $display("FAIL empty_done_width: got %b want 0", o_scan_done);
        end
        repeat (3) step();
        n_vec++;
        if (busy_cnt != b0 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL empty_counts: busy_cycles=%0d scans=%0d want 0 and 1",
                     busy_cnt - b0, done_cnt - d0);
        end
    endtask

    task automatic test_periodic();
        int ovr0;
        int done0;
        int next_tick;
        logic [3:0] m;
        ovr0  = ovr_cnt;
        done0 = done_cnt;
        m = 4'($urandom_range(1, 15));
        ch_mask = m;
        en = 1'b1;
        next_tick = cyc + PERIOD;
        while (cyc < next_tick - 1) step();
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL early_tick: busy=%b want 0", o_busy);
        end
        step();
        do_scan(m, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (ovr_cnt - ovr0 != 1) begin
            n_err++;
            $display("FAIL overrun_count: got %0d want 1", ovr_cnt - ovr0);
        end
        m = 4'($urandom_range(1, 15));
        ch_mask = m;
        next_tick += PERIOD;
        while (cyc < next_tick - 1) step();
        start = 1'b1;
        step();
        start = 1'b0;
        do_scan(m, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (ovr_cnt - ovr0 != 1) begin
            n_err++;
            $display("FAIL coincident_overrun: got %0d want 1", ovr_cnt - ovr0);
        end
        repeat (450) step();
        n_vec++;
        if (done_cnt - done0 != 2 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_stop: scans=%0d busy=%b want 2 and 0",
                     done_cnt - done0, o_busy);
        end
    endtask

    task automatic test_random_scans();
        logic [3:0] m;
        repeat (6) begin
            m = 4'($urandom_range(1, 15));
            start_scan(m);
            do_scan(m, 1'b1, 32'd0, 32'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 5)) step();
        end
    endtask

    task automatic test_reset_mid_accum();
        start_scan(4'b0110);
        repeat (SETTLE) step();
        smp_valid = 1'b1;
        smp_data  = 8'($urandom);
        step();
        smp_data  = 8'($urandom);
        step();
        smp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_accum_reset");
        for (int c = 0; c < N_CH; c++) exp_rf[c] = '0;
        last_sel = '0;
        rd_ch = 2'd1;
        #1;
        n_vec++;
        if (o_rd_data !== 8'd0) begin
            n_err++;
            $display("FAIL partial_write: rd_data[1]=%0d want 0", o_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_scan(4'b0110);
        do_scan(4'b0110, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) exp_rf[c] = '0;
        test_reset();
        test_idle();
        test_two_channel();
        test_settle_discard();
        test_empty_mask();
        test_periodic();
        test_random_scans();
        test_reset_mid_accum();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
